// File: rtl/cache_mem_pkg.sv
// Shared types and constants for the L1 cache and its backing memory.
// Line geometry here must match the cache that sits upstream.
package cache_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_t;

  localparam int BLOCK_WIDTH     = 128;
  localparam int WORD_WIDTH      = 32;
  localparam int WORD_OFFSET_LEN = 2;

endpackage

// File: rtl/block_ram_sp.sv
// Single-port line RAM: synchronous write, registered read.
// Only the read register is reset; the array powers up undefined.
module block_ram_sp #(
  parameter int WIDTH      = 128,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= wdata;
  end

  // Read register holds its line until the next read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/cache_backing_memory.sv
// Line-granular main memory behind the L1 cache with programmable latency.
// Define MEM_STATS_EN to add read/write/busy counters and stats ports.
module cache_backing_memory #(
  parameter int ADDR_WIDTH  = 32,
  parameter int BLOCK_WIDTH = cache_mem_pkg::BLOCK_WIDTH,
  parameter int DEPTH_LOG2  = 10,
  parameter int RD_LATENCY  = 4,
  parameter int WR_LATENCY  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cache2mem_valid,
  input  logic                   cache2mem_rw,
  input  logic [ADDR_WIDTH-1:0]  cache2mem_addr,
  input  logic [BLOCK_WIDTH-1:0] cache2mem_data,
  output logic [BLOCK_WIDTH-1:0] mem2cache_data,
`ifdef MEM_STATS_EN
  input  logic                   stats_clr,
  output logic [31:0]            stat_rd_cnt,
  output logic [31:0]            stat_wr_cnt,
  output logic [31:0]            stat_busy_cyc,
`endif
  output logic                   mem2cache_ready
);

  import cache_mem_pkg::*;

  localparam int IDX_LO = WORD_OFFSET_LEN;
  localparam int IDX_HI = DEPTH_LOG2 + WORD_OFFSET_LEN - 1;
  localparam logic [7:0] RD_LOAD = 8'(RD_LATENCY - 1);
  localparam logic [7:0] WR_LOAD = 8'(WR_LATENCY - 1);

  mem_state_t state;
  mem_state_t state_nx;

  logic [7:0]             cnt;
  logic                   rw_q;
  logic [DEPTH_LOG2-1:0]  idx_q;
  logic [BLOCK_WIDTH-1:0] data_q;
  logic                   ram_en;
  logic                   accept;

  // Offset bits and aliasing high bits take no part in indexing
  logic unused_addr;
  assign unused_addr = ^{cache2mem_addr[ADDR_WIDTH-1:IDX_HI+1],
                         cache2mem_addr[IDX_LO-1:0]};

  assign accept = (state == IDLE) && cache2mem_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (cache2mem_valid) state_nx = WAIT;
      WAIT:    if (cnt == 8'd0) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem2cache_ready = (state == RESP);
    ram_en          = (state == WAIT) && (cnt == 8'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      rw_q   <= 1'b0;
      idx_q  <= '0;
      data_q <= '0;
    end else if (accept) begin
      cnt    <= cache2mem_rw ? WR_LOAD : RD_LOAD;
      rw_q   <= cache2mem_rw;
      idx_q  <= cache2mem_addr[IDX_HI:IDX_LO];
      data_q <= cache2mem_data;
    end else if (state == WAIT && cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  block_ram_sp #(
    .WIDTH      (BLOCK_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .en    (ram_en),
    .we    (rw_q),
    .addr  (idx_q),
    .wdata (data_q),
    .rdata (mem2cache_data)
  );

`ifdef MEM_STATS_EN
  // Saturating counters; clear has priority over increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_rd_cnt   <= '0;
      stat_wr_cnt   <= '0;
      stat_busy_cyc <= '0;
    end else if (stats_clr) begin
      stat_rd_cnt   <= '0;
      stat_wr_cnt   <= '0;
      stat_busy_cyc <= '0;
    end else begin
      if (state == RESP && !rw_q && stat_rd_cnt != '1)
        stat_rd_cnt <= stat_rd_cnt + 32'd1;
      if (state == RESP && rw_q && stat_wr_cnt != '1)
        stat_wr_cnt <= stat_wr_cnt + 32'd1;
      if (state != IDLE && stat_busy_cyc != '1)
        stat_busy_cyc <= stat_busy_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_backing_memory.sv
// Scoreboard bench for cache_backing_memory: directed line reads/writes.
// Define MEM_STATS_EN to also exercise the statistics counters.
module tb_cache_backing_memory;

  localparam int RD_LAT = 4;
  localparam int WR_LAT = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         valid = 1'b0;
  logic         rw = 1'b0;
  logic [31:0]  addr = '0;
  logic [127:0] wdata = '0;
  logic [127:0] rdata;
  logic         ready;
`ifdef MEM_STATS_EN
  logic         stats_clr = 1'b0;
  logic [31:0]  stat_rd_cnt;
  logic [31:0]  stat_wr_cnt;
  logic [31:0]  stat_busy_cyc;
`endif

  cache_backing_memory dut (
    .clk             (clk),
    .rst             (rst),
    .cache2mem_valid (valid),
    .cache2mem_rw    (rw),
    .cache2mem_addr  (addr),
    .cache2mem_data  (wdata),
    .mem2cache_data  (rdata),
`ifdef MEM_STATS_EN
    .stats_clr       (stats_clr),
    .stat_rd_cnt     (stat_rd_cnt),
    .stat_wr_cnt     (stat_wr_cnt),
    .stat_busy_cyc   (stat_busy_cyc),
`endif
    .mem2cache_ready (ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    int           due;
    string        name;
  } exp_t;

  exp_t         q[$];
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  logic [127:0] last_rd = '0;

  localparam logic [127:0] D1 = 128'hDEAD_0001_2222_3333_4444_5555_6666_BEEF;
  localparam logic [127:0] LA = 128'hAAAA_0000_1111_2222_3333_4444_5555_0A0A;
  localparam logic [127:0] Z0 = 128'h0000_0000_0000_0000_0000_0000_0000_5A00;
  localparam logic [127:0] Z1 = 128'h1111_1000_0000_0000_0000_0000_0000_5A01;
  localparam logic [127:0] WB = 128'h0BAD_CAFE_0000_0200_1357_9BDF_2468_ACE0;
  localparam logic [127:0] LB = 128'hB0B0_B0B0_0000_0080_0000_0000_0000_00BB;
  localparam logic [127:0] LC = 128'hC0C0_C0C0_0000_0080_0000_0000_0000_00CC;
  localparam logic [127:0] JK = 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888;
  localparam logic [127:0] S0 = 128'h5300_0000_0000_0000_0000_0000_0000_0300;
  localparam logic [127:0] S1 = 128'h5304_0000_0000_0000_0000_0000_0000_0304;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every ready pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst && ready) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ready cyc=%0d got ready=1 want no pulse", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if (cyc != e.due) begin
          failures++;
          $display("FAIL %s_timing got cyc=%0d want cyc=%0d", e.name, cyc, e.due);
        end
        checks++;
        if (rdata !== e.data) begin
          failures++;
          $display("FAIL %s_data got %h want %h", e.name, rdata, e.data);
        end
      end
    end
  end

  task automatic push_exp(input logic r, input logic [127:0] exp_rd,
                          input string name);
    exp_t e;
    e.due  = cyc + 1 + (r ? WR_LAT : RD_LAT);
    e.data = r ? last_rd : exp_rd;
    e.name = name;
    if (!r) last_rd = exp_rd;
    q.push_back(e);
  endtask

  task automatic wait_done(input string name);
    bit done = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      #1;
      if (q.size() == 0) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout got pending=%0d want 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic issue(input logic r, input logic [31:0] a,
                       input logic [127:0] d, input logic [127:0] exp_rd,
                       input string name);
    @(negedge clk);
    valid = 1'b1;
    rw    = r;
    addr  = a;
    wdata = d;
    push_exp(r, exp_rd, name);
    @(negedge clk);
    valid = 1'b0;
    wait_done(name);
  endtask

  task automatic check(input string name, input logic [127:0] got,
                       input logic [127:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  initial begin
    int seen;
    repeat (2) @(negedge clk);
    check("reset_ready", 128'(ready), 128'd0);
    check("reset_data", rdata, '0);
`ifdef MEM_STATS_EN
    check("reset_rd_cnt", 128'(stat_rd_cnt), 128'd0);
    check("reset_busy", 128'(stat_busy_cyc), 128'd0);
`endif
    rst = 1'b0;

    issue(1'b1, 32'h0000_0040, D1, '0, "wr_40");
    issue(1'b0, 32'h0000_0040, '0, D1, "rd_40");

    issue(1'b1, 32'h0000_0010, LA, '0, "wr_10");
    issue(1'b0, 32'h0000_0013, '0, LA, "rd_13_offset");

    issue(1'b1, 32'h0000_0000, Z0, '0, "wr_0");
    issue(1'b0, 32'h0000_0000, '0, Z0, "rd_0");
    issue(1'b1, 32'h0000_1000, Z1, '0, "wr_1000_alias");
    issue(1'b0, 32'h0000_0000, '0, Z1, "rd_0_wrapped");

    issue(1'b1, 32'h0000_0200, WB, '0, "wb_200");
    issue(1'b0, 32'h0000_0200, '0, WB, "alloc_200");

    issue(1'b1, 32'h0000_0080, LB, '0, "wr_80");

    // Request lines wiggle during WAIT; latched read of 0x40 must finish
    @(negedge clk);
    valid = 1'b1; rw = 1'b0; addr = 32'h0000_0040;
    push_exp(1'b0, D1, "rd_40_wiggle");
    @(negedge clk);
    valid = 1'b0; rw = 1'b1; addr = 32'h0000_0010; wdata = JK;
    @(negedge clk);
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    wait_done("rd_40_wiggle");
    issue(1'b0, 32'h0000_0010, '0, LA, "rd_10_untouched");

    // Reset in the middle of a write to 0x80
    @(negedge clk);
    valid = 1'b1; rw = 1'b1; addr = 32'h0000_0080; wdata = LC;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_rd = '0;
    check("midrst_data", rdata, '0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ready) seen++;
    end
    check("midrst_no_ready", 128'(seen), 128'd0);
    issue(1'b0, 32'h0000_0080, '0, LB, "rd_80_after_rst");

    issue(1'b0, 32'h0000_0040, '0, D1, "rd_40_again");
    issue(1'b1, 32'h0000_0300, S0, '0, "wr_300");
    issue(1'b1, 32'h0000_0304, S1, '0, "wr_304");
    issue(1'b0, 32'h0000_0300, '0, S0, "rd_300");

`ifdef MEM_STATS_EN
    @(negedge clk);
    check("stat_rd", 128'(stat_rd_cnt), 128'd3);
    check("stat_wr", 128'(stat_wr_cnt), 128'd2);
    check("stat_busy", 128'(stat_busy_cyc),
          128'(3 * (RD_LAT + 1) + 2 * (WR_LAT + 1)));
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    check("clr_rd", 128'(stat_rd_cnt), 128'd0);
    check("clr_wr", 128'(stat_wr_cnt), 128'd0);
    check("clr_busy", 128'(stat_busy_cyc), 128'd0);
`endif

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
